// File: rtl/mul_sequencer.sv
// Iterative multiplier with sequencing FSM for the EX stage of the pipelined core.
// Consumes CHUNK_W multiplier bits per cycle and returns the low DATA_W product bits.
// Optional build macro: MUL_EARLY_ZERO_EN (skip iterations once the remaining multiplier is zero).
module mul_sequencer #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CHUNK_W = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam int unsigned N_ITER = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Reject configurations where the multiplier does not split into whole chunks
    generate
        if ((DATA_W % CHUNK_W) != 0) begin : g_bad_cfg
            $error("mul_sequencer: DATA_W must be an integer multiple of CHUNK_W");
        end
    endgenerate

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [DATA_W-1:0] mcand, mcand_nxt;
    logic [DATA_W-1:0] mplier, mplier_nxt;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] mplier_shr;
    logic              accept;

    // Partial product of the multiplicand with the current low multiplier chunk, mod 2^DATA_W
    assign partial    = mcand * DATA_W'(mplier[CHUNK_W-1:0]);
    assign mplier_shr = mplier >> CHUNK_W;
    assign accept     = (state == S_IDLE) && start && !flush;

    // State and datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= S_IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    mcand_nxt  = op_a;
                    mplier_nxt = op_b;
                    acc_nxt    = '0;
                    count_nxt  = '0;
`ifdef MUL_EARLY_ZERO_EN
                    if ((op_a == '0) || (op_b == '0)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_BUSY;
                    end
`else
                    state_nxt  = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                if (flush) begin
                    // Killed instruction: accumulator contents no longer matter
                    state_nxt = S_IDLE;
                end else begin
                    acc_nxt    = acc + partial;
                    mcand_nxt  = mcand << CHUNK_W;
                    mplier_nxt = mplier_shr;
                    count_nxt  = count + CNT_W'(1);
`ifdef MUL_EARLY_ZERO_EN
                    if ((count == CNT_LAST) || (mplier_shr == '0)) begin
                        state_nxt = S_DONE;
                    end
`else
                    if (count == CNT_LAST) begin
                        state_nxt = S_DONE;
                    end
`endif
                end
            end
            S_DONE: begin
                // A start seen here is the instruction just completed; do not re-accept it
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode; reset forces every output low immediately
    assign stall        = !arst && (accept || (state == S_BUSY));
    assign busy         = (state == S_BUSY);
    assign result_valid = (state == S_DONE);
    assign result       = (state == S_DONE) ? acc : '0;

endmodule
